// File: rtl/tcdm_responder_pkg.sv
// Shared types and legal-range constants for the TCDM responder model.
package tcdm_responder_package;

  localparam int LATENCY_MIN      = 1;
  localparam int LATENCY_MAX      = 4;
  localparam int STALL_PERIOD_MIN = 2;
  localparam int STALL_PERIOD_MAX = 255;

  typedef struct packed {
    logic [31:0] n_reads;
    logic [31:0] n_writes;
  } flags_responder_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tcdm_responder_if.sv
// TCDM request/response bundle between a master and the responder.
// Handshake: a request transfers in any cycle where tcdm_req_i and tcdm_gnt_o are
// both 1; tcdm_r_valid_o is a one-cycle strobe with no backpressure.
interface tcdm_responder_if #(
  parameter int DW = 64,
  parameter int AW = 32
);
  logic            tcdm_req_i;
  logic            tcdm_gnt_o;
  logic [AW-1:0]   tcdm_add_i;
  logic            tcdm_wen_i;
  logic [DW-1:0]   tcdm_data_i;
  logic [DW/8-1:0] tcdm_be_i;
  logic [DW-1:0]   tcdm_r_data_o;
  logic            tcdm_r_valid_o;

  modport master (
    output tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_data_i, tcdm_be_i,
    input  tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
  );

  modport slave (
    input  tcdm_req_i, tcdm_add_i, tcdm_wen_i, tcdm_data_i, tcdm_be_i,
    output tcdm_gnt_o, tcdm_r_data_o, tcdm_r_valid_o
  );
endinterface

// File: rtl/tcdm_responder_pipe.sv
// LATENCY-deep valid/data shift pipeline; each stage's data only loads alongside a
// valid, so the output data holds its last response between strobes.
module tcdm_responder_pipe #(
  parameter int LATENCY = 1,
  parameter int DW      = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [DW-1:0]      data_q [LATENCY];
  logic [DW-1:0]      data_d [LATENCY];

  always_comb begin
    vld_d = '0;
    for (int i = 0; i < LATENCY; i++) data_d[i] = data_q[i];
    if (!clear_i) begin
      vld_d[0] = valid_i;
      if (valid_i) data_d[0] = data_i;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= data_d[i];
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/tcdm_responder.sv
// Behavioural TCDM slave: byte-enabled word memory, optional periodic grant stalls,
// fixed-latency responses and saturating access counters.
module tcdm_responder
  import tcdm_responder_package::*;
#(
  parameter int DW           = 64,
  parameter int AW           = 32,
  parameter int NB_WORDS     = 1024,
  parameter int LATENCY      = 1,
  parameter int STALL_PERIOD = 4,
  parameter bit WRITE_RVALID = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                stall_en_i,
  tcdm_responder_if.slave     tcdm,
  output logic [31:0]         n_reads_o,
  output logic [31:0]         n_writes_o
);

  localparam int OFF = $clog2(DW/8);
  localparam int IW  = $clog2(NB_WORDS);
  localparam logic [7:0] STALL_LAST = 8'(STALL_PERIOD - 1);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("tcdm_responder: LATENCY out of range");
  end
  if (STALL_PERIOD < STALL_PERIOD_MIN || STALL_PERIOD > STALL_PERIOD_MAX) begin : g_bad_stall
    $error("tcdm_responder: STALL_PERIOD out of range");
  end

  logic [7:0]       stall_cnt_q, stall_cnt_d;
  flags_responder_t flags_q, flags_d;
  logic [DW-1:0]    mem_q [NB_WORDS];
  logic [IW-1:0]    word_idx;
  logic             gnt, is_read, is_write;
  logic             pipe_vld_in;
  logic [DW-1:0]    pipe_data_in;
  logic             unused_add;

  assign word_idx   = tcdm.tcdm_add_i[OFF +: IW];
  assign unused_add = ^tcdm.tcdm_add_i;

  // Reset and clear both block the grant so nothing is accepted while state is wiped.
  assign gnt = tcdm.tcdm_req_i & ~rst_i & ~clear_i &
               (~stall_en_i | (stall_cnt_q == 8'd0));
  assign is_read  = gnt &  tcdm.tcdm_wen_i;
  assign is_write = gnt & ~tcdm.tcdm_wen_i;
  assign tcdm.tcdm_gnt_o = gnt;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 8'd1;
    if (clear_i || !stall_en_i || stall_cnt_q == STALL_LAST) stall_cnt_d = 8'd0;
  end

  always_comb begin
    flags_d = flags_q;
    if (clear_i) begin
      flags_d = '0;
    end else begin
      if (is_read)  flags_d.n_reads  = sat_inc(flags_q.n_reads);
      if (is_write) flags_d.n_writes = sat_inc(flags_q.n_writes);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 8'd0;
      flags_q     <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flags_q     <= flags_d;
    end
  end

  // Memory contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (is_write) begin
      for (int b = 0; b < DW/8; b++) begin
        if (tcdm.tcdm_be_i[b]) mem_q[word_idx][b*8 +: 8] <= tcdm.tcdm_data_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    pipe_vld_in  = is_read | (is_write & WRITE_RVALID);
    pipe_data_in = '0;
    if (is_read) pipe_data_in = mem_q[word_idx];
  end

  tcdm_responder_pipe #(
    .LATENCY (LATENCY),
    .DW      (DW)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .valid_i (pipe_vld_in),
    .data_i  (pipe_data_in),
    .valid_o (tcdm.tcdm_r_valid_o),
    .data_o  (tcdm.tcdm_r_data_o)
  );

  assign n_reads_o  = flags_q.n_reads;
  assign n_writes_o = flags_q.n_writes;

endmodule

// File: tb/tb_tcdm_responder.sv
// Directed bench for tcdm_responder: two instances (write responses off / on) with
// queue-based scoreboards checked by independent monitors.
module tb_tcdm_responder;
  import tcdm_responder_package::*;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int NBW   = 1024;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;
  localparam int SP    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_a = 1'b0, stall_a = 1'b0;
  logic clear_b = 1'b0, stall_b = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcdm_responder_if #(.DW(DW), .AW(AW)) bus_a ();
  tcdm_responder_if #(.DW(DW), .AW(AW)) bus_b ();
  logic [31:0] nr_a, nw_a, nr_b, nw_b;

  tcdm_responder #(.DW(DW), .AW(AW), .NB_WORDS(NBW), .LATENCY(LAT_A),
                   .STALL_PERIOD(SP), .WRITE_RVALID(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_a), .stall_en_i(stall_a),
    .tcdm(bus_a.slave), .n_reads_o(nr_a), .n_writes_o(nw_a));

  tcdm_responder #(.DW(DW), .AW(AW), .NB_WORDS(NBW), .LATENCY(LAT_B),
                   .STALL_PERIOD(SP), .WRITE_RVALID(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_b), .stall_en_i(stall_b),
    .tcdm(bus_b.slave), .n_reads_o(nr_b), .n_writes_o(nw_b));

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q_a[$];
  int            exp_cyc_a[$];
  logic [DW-1:0] exp_q_b[$];
  int            exp_cyc_b[$];
  int            rv_cnt_a = 0, rv_cnt_b = 0;
  int            n_vec = 0, n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_vec++;
    n_miss++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.tcdm_r_valid_o) begin
        rv_cnt_a++;
        if (exp_q_a.size() == 0) fail_now("a_unexpected_rvalid", "got r_valid=1, want none");
        else begin
          check("a_rdata", bus_a.tcdm_r_data_o, exp_q_a.pop_front());
          check("a_rcycle", 64'(cyc), 64'(exp_cyc_a.pop_front()));
        end
      end else if (exp_cyc_a.size() > 0 && cyc >= exp_cyc_a[0]) begin
        fail_now("a_missing_rvalid", "got r_valid=0, want response");
        void'(exp_q_a.pop_front());
        void'(exp_cyc_a.pop_front());
      end
      if (bus_b.tcdm_r_valid_o) begin
        rv_cnt_b++;
        if (exp_q_b.size() == 0) fail_now("b_unexpected_rvalid", "got r_valid=1, want none");
        else begin
          check("b_rdata", bus_b.tcdm_r_data_o, exp_q_b.pop_front());
          check("b_rcycle", 64'(cyc), 64'(exp_cyc_b.pop_front()));
        end
      end else if (exp_cyc_b.size() > 0 && cyc >= exp_cyc_b[0]) begin
        fail_now("b_missing_rvalid", "got r_valid=0, want response");
        void'(exp_q_b.pop_front());
        void'(exp_cyc_b.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  // Leaves req asserted on return so consecutive calls issue back-to-back.
  task automatic access_a(input bit rd, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [7:0] be, input logic [63:0] exp_rd,
                          input bit want_resp, output int gcyc);
    bus_a.tcdm_req_i  = 1'b1;
    bus_a.tcdm_wen_i  = rd;
    bus_a.tcdm_add_i  = addr;
    bus_a.tcdm_data_i = wdata;
    bus_a.tcdm_be_i   = be;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_a.tcdm_gnt_o) begin
        gcyc = cyc;
        if (want_resp) begin
          exp_q_a.push_back(exp_rd);
          exp_cyc_a.push_back(cyc + LAT_A);
        end
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    gcyc = -1;
    fail_now("a_grant_timeout", "no grant within 20 cycles");
  endtask

  task automatic idle(input int n);
    bus_a.tcdm_req_i = 1'b0;
    bus_b.tcdm_req_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int g0, g1, rv0;
    int gs[4];
    bus_a.tcdm_req_i = 1'b1; bus_a.tcdm_wen_i = 1'b1; bus_a.tcdm_add_i = '0;
    bus_a.tcdm_data_i = '0; bus_a.tcdm_be_i = '0;
    bus_b.tcdm_req_i = 1'b0; bus_b.tcdm_wen_i = 1'b1; bus_b.tcdm_add_i = '0;
    bus_b.tcdm_data_i = '0; bus_b.tcdm_be_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(bus_a.tcdm_gnt_o), 64'd0);
    check("rst_rvalid", 64'(bus_a.tcdm_r_valid_o), 64'd0);
    check("rst_rdata", bus_a.tcdm_r_data_o, 64'd0);
    check("rst_nreads", 64'(nr_a), 64'd0);
    check("rst_nwrites", 64'(nw_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_a.tcdm_req_i = 1'b0;
    idle(2);

    // Write then read-after-write of the same word on the next cycle.
    access_a(1'b0, 32'h40, 64'hDEADBEEF_01234567, 8'hFF, '0, 1'b0, g0);
    access_a(1'b1, 32'h40, '0, 8'h00, 64'hDEADBEEF_01234567, 1'b1, g1);
    check("raw_back_to_back", 64'(g1 - g0), 64'd1);
    idle(4);
    check("t1_nwrites", 64'(nw_a), 64'd1);
    check("t1_nreads", 64'(nr_a), 64'd1);

    // Partial byte-enable overwrite of word 3.
    access_a(1'b0, 32'h18, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, '0, 1'b0, g0);
    access_a(1'b0, 32'h18, 64'h0, 8'h0F, '0, 1'b0, g0);
    access_a(1'b1, 32'h18, '0, 8'h00, 64'hFFFFFFFF_00000000, 1'b1, g0);
    idle(4);

    // A write with WRITE_RVALID=0 produces no response.
    rv0 = rv_cnt_a;
    access_a(1'b0, 32'h20, 64'h1234, 8'hFF, '0, 1'b0, g0);
    idle(6);
    check("a_write_no_rvalid", 64'(rv_cnt_a - rv0), 64'd0);

    // Address wrap modulo NB_WORDS and ignored byte-offset bits.
    access_a(1'b0, 32'h8, 64'hA5A5_5A5A_C3C3_3C3C, 8'hFF, '0, 1'b0, g0);
    access_a(1'b1, 32'(NBW*DW/8 + 8), '0, 8'h00, 64'hA5A5_5A5A_C3C3_3C3C, 1'b1, g0);
    access_a(1'b1, 32'h1B, '0, 8'h00, 64'hFFFFFFFF_00000000, 1'b1, g0);
    idle(4);

    // Back-to-back reads under periodic stall: one grant every SP cycles.
    stall_a = 1'b1;
    access_a(1'b1, 32'h40, '0, 8'h00, 64'hDEADBEEF_01234567, 1'b1, gs[0]);
    access_a(1'b1, 32'h18, '0, 8'h00, 64'hFFFFFFFF_00000000, 1'b1, gs[1]);
    access_a(1'b1, 32'h08, '0, 8'h00, 64'hA5A5_5A5A_C3C3_3C3C, 1'b1, gs[2]);
    access_a(1'b1, 32'h20, '0, 8'h00, 64'h0000_0000_0000_1234, 1'b1, gs[3]);
    idle(1);
    stall_a = 1'b0;
    for (int i = 1; i < 4; i++) check("stall_grant_spacing", 64'(gs[i] - gs[i-1]), 64'(SP));
    idle(6);
    check("t5_nreads", 64'(nr_a), 64'd8);
    check("t5_nwrites", 64'(nw_a), 64'd5);

    // Clear one cycle after a read grant flushes it and blocks a concurrent request.
    rv0 = rv_cnt_a;
    access_a(1'b1, 32'h40, '0, 8'h00, '0, 1'b0, g0);
    clear_a = 1'b1;
    @(negedge clk);
    check("gnt_during_clear", 64'(bus_a.tcdm_gnt_o), 64'd0);
    @(posedge clk); #1;
    clear_a = 1'b0;
    idle(5);
    check("clear_flush", 64'(rv_cnt_a - rv0), 64'd0);
    check("clear_nreads", 64'(nr_a), 64'd0);
    check("clear_nwrites", 64'(nw_a), 64'd0);
    access_a(1'b1, 32'h40, '0, 8'h00, 64'hDEADBEEF_01234567, 1'b1, g0);
    idle(4);

    // Reset one cycle after a read grant: response discarded, memory kept.
    rv0 = rv_cnt_a;
    access_a(1'b1, 32'h18, '0, 8'h00, '0, 1'b0, g0);
    rst = 1'b1;
    bus_a.tcdm_req_i = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", 64'(bus_a.tcdm_r_valid_o), 64'd0);
    check("midrst_nreads", 64'(nr_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    check("reset_discard", 64'(rv_cnt_a - rv0), 64'd0);
    access_a(1'b1, 32'h18, '0, 8'h00, 64'hFFFFFFFF_00000000, 1'b1, g0);
    idle(4);
    check("post_rst_nreads", 64'(nr_a), 64'd1);

    // WRITE_RVALID=1 instance: write yields a zero-data response, then a read.
    bus_b.tcdm_req_i = 1'b1; bus_b.tcdm_wen_i = 1'b0; bus_b.tcdm_add_i = 32'h10;
    bus_b.tcdm_data_i = 64'hFFFFFFFF_FFFFFFFF; bus_b.tcdm_be_i = 8'hFF;
    @(negedge clk);
    check("b_write_gnt", 64'(bus_b.tcdm_gnt_o), 64'd1);
    exp_q_b.push_back(64'd0);
    exp_cyc_b.push_back(cyc + LAT_B);
    @(posedge clk); #1;
    bus_b.tcdm_wen_i = 1'b1;
    @(negedge clk);
    check("b_read_gnt", 64'(bus_b.tcdm_gnt_o), 64'd1);
    exp_q_b.push_back(64'hFFFFFFFF_FFFFFFFF);
    exp_cyc_b.push_back(cyc + LAT_B);
    @(posedge clk); #1;
    idle(8);
    check("b_rvalid_count", 64'(rv_cnt_b), 64'd2);
    check("b_nwrites", 64'(nw_b), 64'd1);
    check("b_nreads", 64'(nr_b), 64'd1);

    check("a_queue_drained", 64'(exp_q_a.size()), 64'd0);
    check("b_queue_drained", 64'(exp_q_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tcdm_responder.md
TCDM_RESPONDER -- requirements
Module: tcdm_responder

Interface
REQ-001 Parameter DW, default 64, TCDM data width in bits; a multiple of 32.
REQ-002 Parameter AW, default 32, TCDM byte-address width.
REQ-003 Parameter NB_WORDS, default 1024, memory depth in DW-bit words; a power of 2.
REQ-004 Parameter LATENCY, default 1, grant-to-r_valid cycles; legal range 1..4.
REQ-005 Parameter STALL_PERIOD, default 4, grant period when stalling is enabled; legal range 2..255.
REQ-006 Parameter WRITE_RVALID, default 0; when 1, writes also produce an r_valid strobe.
REQ-007 clk_i  in  1  the single clock; all state is on its rising edge.
REQ-008 rst_i  in  1  asynchronous, active-high reset.
REQ-009 clear_i  in  1  synchronous clear.
REQ-010 stall_en_i  in  1  enables the periodic grant-stall pattern.
REQ-011 tcdm_req_i  in  1  request valid.
REQ-012 tcdm_gnt_o  out  1  request accepted this cycle.
REQ-013 tcdm_add_i  in  AW  byte address.
REQ-014 tcdm_wen_i  in  1  1 = read, 0 = write.
REQ-015 tcdm_data_i  in  DW  write data.
REQ-016 tcdm_be_i  in  DW/8  byte enables (write only).
REQ-017 tcdm_r_data_o  out  DW  read data.
REQ-018 tcdm_r_valid_o  out  1  response strobe; there is no response backpressure.
REQ-019 n_reads_o, n_writes_o  out  32 each  counts of accepted accesses.

Function
REQ-020 A request is accepted in a cycle iff tcdm_req_i and tcdm_gnt_o are both 1; at most one access is accepted per cycle.
REQ-021 tcdm_gnt_o is combinational: it equals tcdm_req_i when stall_en_i=0, and equals tcdm_req_i AND (stall_cnt==0) when stall_en_i=1.
REQ-022 stall_cnt counts 0..STALL_PERIOD-1, wrapping to 0; it advances every cycle while stall_en_i=1 and holds at 0 while stall_en_i=0.
REQ-023 Word index = tcdm_add_i[log2(DW/8) +: log2(NB_WORDS)]; lower address bits are ignored; higher bits wrap modulo NB_WORDS.
REQ-024 An accepted write updates only the bytes whose tcdm_be_i bit is 1, at the end of the acceptance cycle.
REQ-025 An accepted read in cycle N samples memory in cycle N and raises r_valid for exactly one cycle at N+LATENCY with that data.
REQ-026 A write in cycle N followed by a read of the same word in cycle N+1 returns the new data.
REQ-027 Responses travel through a LATENCY-deep valid/data shift pipeline, so back-to-back reads return back-to-back r_valid in issue order.
REQ-028 An accepted write produces r_valid at N+LATENCY with r_data all zeros iff WRITE_RVALID=1; otherwise a write produces no r_valid.
REQ-029 tcdm_r_data_o holds its last value when r_valid=0.
REQ-030 The counters increment by 1 per accepted read or write respectively and saturate at 2^32-1.
REQ-031 clear_i=1 flushes the pipeline (no r_valid in the next cycle), zeroes stall_cnt and both counters, and leaves memory contents unchanged; a request presented in the same cycle as clear_i is not granted.

Reset
REQ-032 While rst_i=1: tcdm_gnt_o=0, tcdm_r_valid_o=0, tcdm_r_data_o=0, n_reads_o=0, n_writes_o=0, stall_cnt=0, and the pipeline is empty.
REQ-033 Memory contents are not reset; a reset applied mid-operation discards all in-flight responses.

Structure
REQ-034 The package tcdm_responder_package holds the flags_responder_t struct (n_reads, n_writes) and the legal-range constants for LATENCY and STALL_PERIOD.
REQ-035 The response pipeline is the sub-module tcdm_responder_pipe (parameters LATENCY and DW; ports valid in, data in, valid out, data out, clear).
REQ-036 The memory is inferred as a single-port array of DW-bit words with byte-write enables.

Verification
REQ-037 Write 0xDEADBEEF_01234567 to address 0x40 with be=0xFF, then read 0x40 with LATENCY=2 -> r_valid two cycles after grant with the same data, and n_writes=1, n_reads=1.
REQ-038 Write 0xFF..FF to word 3, then write be=0x0F with data 0 -> a read returns 0xFFFFFFFF_00000000.
REQ-039 Four back-to-back reads with stall_en=1 and STALL_PERIOD=4 -> grants on every 4th cycle only, each r_valid exactly LATENCY cycles after its grant, data returned in issue order.
REQ-040 WRITE_RVALID=0 then 1, one write each -> no r_valid in the first case; in the second, one r_valid at N+LATENCY with data 0.
REQ-041 Read address NB_WORDS*DW/8 + 8 -> returns word 1; rst_i asserted one cycle after a read grant -> no r_valid is ever produced for that read.
